// File: rtl/ej32_pkg.sv
// rtl/ej32_pkg.sv - shared types and constants for the eJ32 memory responder
package ej32_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    W2   = 2'd1,
    W1   = 2'd2,
    W0   = 2'd3
  } mem_st_t;

  localparam logic [1:0] WSZ_B = 2'd0;
  localparam logic [1:0] WSZ_H = 2'd1;
  localparam logic [1:0] WSZ_W = 2'd3;

endpackage

// File: rtl/ej32_spram.sv
// rtl/ej32_spram.sv - single-port byte RAM, synchronous write-first read, no reset
module ej32_spram #(
  parameter int DEPTH = 8192,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/ej32_mem.sv
// rtl/ej32_mem.sv - eJ32 memory responder: 1-cycle byte reads, big-endian serialised stores
module ej32_mem
  import ej32_pkg::*;
#(
  parameter int ASZ       = 17,
  parameter int DSZ       = 32,
  parameter int MEM_DEPTH = 8192
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [ASZ-1:0] addr_i,
  input  logic           rd_i,
  input  logic           we_i,
  input  logic [1:0]     wsz_i,
  input  logic [DSZ-1:0] wdata_i,
  output logic [7:0]     data_o,
  output logic           dvld_o,
  output logic           busy_o
);

  localparam int AW = $clog2(MEM_DEPTH);

  mem_st_t        st;
  logic [ASZ-1:0] a_q;
  logic [DSZ-1:0] d_q;
  logic           dvld_q;
  logic [7:0]     hold_q;
  logic [7:0]     ram_rdata;
  logic           idle;
  logic           rd_acc;
  logic           ram_en;
  logic           ram_we;
  logic [AW-1:0]  ram_addr;
  logic [7:0]     ram_wdata;
  logic           unused_bits;

  // Only one RAM access per cycle: the accepted request in IDLE, else the next store byte.
  always_comb begin
    idle      = (st == IDLE);
    rd_acc    = idle & rd_i & ~we_i;
    ram_addr  = a_q[AW-1:0];
    ram_wdata = d_q[7:0];
    ram_we    = 1'b0;
    case (st)
      IDLE: begin
        ram_addr = addr_i[AW-1:0];
        ram_we   = we_i;
        case (wsz_i)
          WSZ_W:   ram_wdata = wdata_i[31:24];
          WSZ_H:   ram_wdata = wdata_i[15:8];
          default: ram_wdata = wdata_i[7:0];
        endcase
      end
      W2: begin
        ram_wdata = d_q[23:16];
        ram_we    = 1'b1;
      end
      W1: begin
        ram_wdata = d_q[15:8];
        ram_we    = 1'b1;
      end
      default: begin
        ram_wdata = d_q[7:0];
        ram_we    = 1'b1;
      end
    endcase
    // The RAM has no reset, so block writes while reset is held.
    ram_we = ram_we & rst;
    ram_en = ram_we | rd_acc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st     <= IDLE;
      a_q    <= '0;
      d_q    <= '0;
      dvld_q <= 1'b0;
      hold_q <= 8'h00;
    end else begin
      dvld_q <= rd_acc;
      if (dvld_q) hold_q <= ram_rdata;
      case (st)
        IDLE: begin
          if (we_i) begin
            a_q <= addr_i + ASZ'(1);
            d_q <= wdata_i;
            case (wsz_i)
              WSZ_W:   st <= W2;
              WSZ_H:   st <= W0;
              default: st <= IDLE;
            endcase
          end
        end
        W2: begin
          st  <= W1;
          a_q <= a_q + ASZ'(1);
        end
        W1: begin
          st  <= W0;
          a_q <= a_q + ASZ'(1);
        end
        default: st <= IDLE;
      endcase
    end
  end

  ej32_spram #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Upper address bits alias onto the implemented depth; d_q[31:24] is written on acceptance.
  assign unused_bits = ^{addr_i[ASZ-1:AW], a_q[ASZ-1:AW], d_q[DSZ-1:24]};

  assign data_o = dvld_q ? ram_rdata : hold_q;
  assign dvld_o = dvld_q;
  assign busy_o = ~idle;

endmodule

// File: tb/tb_ej32_mem.sv
// tb/tb_ej32_mem.sv - randomized self-checking bench for ej32_mem against a byte-array model
module tb_ej32_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [16:0] addr_i = '0;
  logic        rd_i = 1'b0;
  logic        we_i = 1'b0;
  logic [1:0]  wsz_i = '0;
  logic [31:0] wdata_i = '0;
  logic [7:0]  data_o;
  logic        dvld_o;
  logic        busy_o;

  int vec = 0;
  int errs = 0;

  logic [7:0]  mem_m [int];
  logic [16:0] written [$];
  logic [7:0]  last_data = 8'h00;
  bit          last_known = 1'b1;

  ej32_mem dut (
    .clk     (clk),
    .rst     (rst),
    .addr_i  (addr_i),
    .rd_i    (rd_i),
    .we_i    (we_i),
    .wsz_i   (wsz_i),
    .wdata_i (wdata_i),
    .data_o  (data_o),
    .dvld_o  (dvld_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [16:0] a, input logic [1:0] sz, input logic [31:0] d,
                          input bit rd_at_accept, input bit rd_busy);
    int n;
    logic [16:0] ai;
    n = (sz == 2'd3) ? 4 : (sz == 2'd1) ? 2 : 1;
    for (int i = 0; i < n; i++) begin
      ai = a + 17'(i);
      mem_m[int'(ai) % 8192] = 8'(d >> (8 * (n - 1 - i)));
      written.push_back(ai);
    end
    addr_i = a; wsz_i = sz; wdata_i = d; we_i = 1'b1; rd_i = rd_at_accept;
    step();
    we_i = 1'b0; addr_i = 17'($urandom); wdata_i = $urandom;
    for (int c = 0; c < n; c++) begin
      vec++;
      if (busy_o !== 1'(c < n - 1)) begin
        errs++;
        $display("FAIL store_busy a=%h sz=%0d c=%0d got %b exp %b", a, sz, c, busy_o, c < n - 1);
      end
      vec++;
      if (dvld_o !== 1'b0 || (last_known && data_o !== last_data)) begin
        errs++;
        $display("FAIL store_quiet a=%h c=%0d got dvld=%b data=%h exp dvld=0 data=%h",
                 a, c, dvld_o, data_o, last_data);
      end
      rd_i = rd_busy && (c < n - 1);
      if (c < n - 1) step();
    end
    rd_i = 1'b0;
  endtask

  task automatic do_reads(input logic [16:0] a, input int n);
    logic [16:0] ai;
    int k;
    for (int i = 0; i < n; i++) begin
      ai = a + 17'(i);
      k = int'(ai) % 8192;
      addr_i = ai; rd_i = 1'b1;
      step();
      vec++;
      if (dvld_o !== 1'b1) begin
        errs++;
        $display("FAIL read_dvld a=%h got %b exp 1", ai, dvld_o);
      end
      if (mem_m.exists(k)) begin
        vec++;
        if (data_o !== mem_m[k]) begin
          errs++;
          $display("FAIL read_data a=%h got %h exp %h", ai, data_o, mem_m[k]);
        end
        last_data = mem_m[k];
        last_known = 1'b1;
      end else begin
        last_known = 1'b0;
      end
    end
    rd_i = 1'b0;
    step();
    vec++;
    if (dvld_o !== 1'b0 || (last_known && data_o !== last_data)) begin
      errs++;
      $display("FAIL read_tail got dvld=%b data=%h exp dvld=0 data=%h", dvld_o, data_o, last_data);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    step();
    step();
    vec++;
    if (busy_o !== 1'b0 || dvld_o !== 1'b0 || data_o !== 8'h00) begin
      errs++;
      $display("FAIL reset got busy=%b dvld=%b data=%h exp 0 0 00", busy_o, dvld_o, data_o);
    end
    rst = 1'b1;
    last_data = 8'h00;
    last_known = 1'b1;
    step();
  endtask

  task automatic test_read();
    do_store(17'h00100, 2'd0, 32'h000000A5, 1'b0, 1'b0);
    do_reads(17'h00100, 1);
  endtask

  task automatic test_word_store();
    do_store(17'h00200, 2'd3, 32'h11223344, 1'b0, 1'b0);
    do_reads(17'h00200, 4);
  endtask

  task automatic test_half_byte();
    do_store(17'h00300, 2'd1, 32'h0000BEEF, 1'b0, 1'b0);
    do_store(17'h00302, 2'd0, 32'h0000007C, 1'b0, 1'b0);
    do_store(17'h00303, 2'd2, 32'h12345699, 1'b0, 1'b0);
    do_reads(17'h00300, 4);
  endtask

  task automatic test_wrap();
    do_store(17'h1FFFE, 2'd3, 32'hCAFEF00D, 1'b0, 1'b1);
    do_reads(17'h1FFFE, 4);
  endtask

  task automatic test_simultaneous();
    do_store(17'h00400, 2'd0, 32'h00000055, 1'b1, 1'b0);
    do_reads(17'h00400, 1);
  endtask

  task automatic test_reset_mid_store();
    do_store(17'h00500, 2'd3, 32'h01020304, 1'b0, 1'b0);
    addr_i = 17'h00500; wsz_i = 2'd3; wdata_i = 32'hDEADBEEF; we_i = 1'b1;
    step();
    we_i = 1'b0;
    rst = 1'b0;
    #1;
    mem_m[32'h500] = 8'hDE;
    last_data = 8'h00;
    last_known = 1'b1;
    vec++;
    if (busy_o !== 1'b0 || dvld_o !== 1'b0 || data_o !== 8'h00) begin
      errs++;
      $display("FAIL mid_store_reset got busy=%b dvld=%b data=%h exp 0 0 00", busy_o, dvld_o, data_o);
    end
    step();
    rst = 1'b1;
    step();
    do_reads(17'h00500, 4);
  endtask

  task automatic test_random();
    logic [16:0] a;
    for (int it = 0; it < 80; it++) begin
      if (written.size() == 0 || $urandom_range(0, 1) == 0) begin
        a = ($urandom_range(0, 3) == 0) ? 17'(17'h1FFFC + 17'($urandom_range(0, 3)))
                                        : 17'($urandom);
        do_store(a, 2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
      end else begin
        a = written[$urandom_range(0, written.size() - 1)];
        do_reads(a, $urandom_range(1, 4));
      end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_word_store();
    test_half_byte();
    test_wrap();
    test_simultaneous();
    test_reset_mid_store();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/ej32_mem.md
Name: ej32_mem

Overview:
- Memory responder at the far end of the eJ32 address bus.
- The branching unit drives addresses and fetch requests, and expects the byte one cycle later. This block returns that byte.
- It also accepts byte, half and word stores from the stack unit and serialises them into big-endian byte writes, raising busy while the write is in progress.
- It sits between the core units and a byte-wide synchronous RAM that maps onto EBR.

Parameters:
- ASZ, 17, address width in bytes (128K space)
- DSZ, 32, store data width
- MEM_DEPTH, 8192, implemented bytes; the address is taken modulo MEM_DEPTH (power of two)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  one clock; reset is asynchronous and active-low
- addr_i  in  ASZ  byte address (br_addr_o of the branching unit)
- rd_i  in  1  read request for addr_i
- we_i  in  1  store request at addr_i
- wsz_i  in  2  store size: 0 = byte, 1 = half, 3 = word; 2 is reserved and treated as byte
- wdata_i  in  DSZ  store data, right-aligned
- data_o  out  8  read data byte
- dvld_o  out  1  data_o holds the result of the previous cycle's read
- busy_o  out  1  multi-byte store in progress; new requests are ignored

Behaviour:
- Reset (rst low, asynchronous): state = IDLE, busy_o = 0, dvld_o = 0, data_o = 0, internal address and data latches = 0. RAM contents are not cleared.
- Reads:
  - rd_i sampled high in cycle N while in IDLE and with we_i low: data_o = mem[addr_i] and dvld_o = 1 in cycle N+1. Fixed latency of 1.
  - dvld_o is a single-cycle pulse per accepted read.
  - data_o holds its last value when no read is accepted.
- Back-to-back reads on consecutive cycles are supported at full throughput (one byte per cycle).
- Stores, big-endian (MSB at the lowest address):
  - Accept cycle N: in IDLE with we_i high, write the most significant stored byte to addr_i. Latch a_q = addr_i + 1 and d_q = wdata_i.
  - Byte: no further cycles; state stays IDLE, busy_o stays 0.
  - Half: writes wdata_i[15:8], then goes to W0. W0 writes d_q[7:0] at a_q and returns to IDLE.
  - Word: writes wdata_i[31:24], then walks W2 -> W1 -> W0. These write d_q[23:16], d_q[15:8] and d_q[7:0] at a_q, a_q+1 and a_q+2.
  - busy_o = 1 whenever the state is not IDLE, i.e. in the cycles after acceptance until the last byte is written. Word store: busy_o high in cycles N+1..N+3. Half store: cycle N+1.
- Simultaneous rd_i and we_i in IDLE: the store wins and the read is dropped (no dvld_o).
- Requests while busy_o = 1 are ignored, with no queuing. The core must stall on busy_o.
- Read-after-write: a read accepted in the cycle after the last store byte returns the new data. This follows from RAM write-first ordering and needs no bypass path.
- Address arithmetic:
  - a_q increments modulo 2^ASZ; physical index = address mod MEM_DEPTH.
  - A word store at 0x1FFFE wraps to 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
- Reset mid-store: the FSM returns to IDLE immediately. Bytes already written remain; unwritten bytes are lost.
- Only one RAM port access occurs per cycle, so a single-port RAM is sufficient.

Decomposition:
- ej32_pkg additions:
  - mem_st_t enum {IDLE, W2, W1, W0}
  - wsz_t constants WSZ_B = 0, WSZ_H = 1, WSZ_W = 3
- Sub-module ej32_spram: single-port byte RAM (MEM_DEPTH x 8) with synchronous read, write-first ordering and no reset. It is inferred to EBR.
- The store FSM, latches and read-valid logic live in ej32_mem.

Test Plan:
- Preload mem[0x100] = 0xA5; rd_i with addr 0x100 in cycle N -> data_o = 0xA5 and dvld_o = 1 in cycle N+1, dvld_o = 0 in N+2.
- Word store 0x11223344 at 0x200, then read 0x200..0x203 back-to-back -> 0x11, 0x22, 0x33, 0x44 on consecutive cycles. busy_o is high for exactly 3 cycles.
- Half store 0xBEEF at 0x300 -> mem[0x300] = 0xBE and mem[0x301] = 0xEF, busy_o high for 1 cycle. Byte store 0x7C at 0x302 -> busy_o never rises.
- Word store 0xCAFEF00D at 0x1FFFE -> 0xCA at 0x1FFFE, 0xFE at 0x1FFFF, 0xF0 at 0x00000, 0x0D at 0x00001. Also drive rd_i during busy -> no dvld_o.
- rd_i and we_i together (byte 0x55 at 0x400) -> mem[0x400] = 0x55 and no dvld_o pulse.
- Word store 0xDEADBEEF at 0x500, with rst pulled low in cycle N+1 -> busy_o = 0 and dvld_o = 0 at once. Memory shows 0xDE at 0x500 only; 0x501..0x503 are unchanged.
